ps2_key_event_decoder: RTL

Parametrised next-generation PS/2 scan-code set 2 decoder. Consumes the byte stream from the PS/2 controller and maintains a 512-bit held-key bitmap. It also produces a buffered make/break/auto-repeat event queue with a valid/ready handshake. Sits between the PS/2 controller and game/UI logic that must not miss events.

---
 rtl/ps2_key_event_decoder.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 decoder.
// Turns the controller's byte stream into a 512-bit held-key bitmap plus a
// show-ahead make/break/auto-repeat event queue with a valid/ready handshake.
//
// Parser states:
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | waiting for the first byte of a sequence
//   ST_EXT      | E0 seen, next byte is an extended make (or F0)
//   ST_BRK      | F0 seen, next byte is a normal break
//   ST_EXT_BRK  | E0 F0 seen, next byte is an extended break
//   ST_PAUSE    | E1 seen, swallowing the rest of the Pause sequence
//
// Key index is {extended, code[7:0]}. Queue entries are {code, break, repeat}.
module ps2_key_event_decoder #(
    parameter int          FIFO_DEPTH   = 8,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            byte_valid,
    input  logic [7:0]                      byte_data,
    output logic [511:0]                    key_down,
    output logic [9:0]                      keys_held,
    output logic                            ev_valid,
    output logic [8:0]                      ev_code,
    output logic                            ev_break,
    output logic                            ev_repeat,
    input  logic                            ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    input  logic                            clr_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0] PAUSE_CODE = 9'h1E1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] skip_cnt;
    logic [2:0] skip_nxt;

    // Parser actions, valid for one cycle alongside the final byte strobe.
    logic       act_make;
    logic       act_break;
    logic       act_pause;
    logic       act_clear;
    logic [8:0] act_code;
    logic       is_err;

    // Datapath decisions derived from the parser action and the bitmap.
    logic        key_bit;
    logic        make_new;
    logic        brk_hit;
    logic        parser_push;
    logic        rep_req;
    logic        rep_grant;
    logic [8:0]  rep_ev_code;

    // Queue signals.
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push_req;
    logic          do_push;
    logic          pop;
    logic [10:0]   push_data;
    logic [10:0]   head;

    // Parser state and Pause skip counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Parser next-state and action decode; only moves on a byte strobe.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        act_make  = 1'b0;
        act_break = 1'b0;
        act_pause = 1'b0;
        act_clear = 1'b0;
        act_code  = 9'd0;
        is_err    = (byte_data == 8'h00) || (byte_data == 8'hFF);
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    case (byte_data)
                        8'hE0: state_nxt = ST_EXT;
                        8'hF0: state_nxt = ST_BRK;
                        8'hE1: begin
                            state_nxt = ST_PAUSE;
                            skip_nxt  = 3'd7;
                        end
                        8'hAA: act_clear = 1'b1;
                        8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE: begin
                        end
                        default: begin
                            act_make = 1'b1;
                            act_code = {1'b0, byte_data};
                        end
                    endcase
                end
                ST_EXT: begin
                    if (is_err || byte_data == 8'h12) begin
                        state_nxt = ST_IDLE;
                    end else if (byte_data == 8'hF0) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        act_make  = 1'b1;
                        act_code  = {1'b1, byte_data};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    if (!is_err) begin
                        act_break = 1'b1;
                        act_code  = {1'b0, byte_data};
                    end
                end
                ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    if (!is_err && byte_data != 8'h12) begin
                        act_break = 1'b1;
                        act_code  = {1'b1, byte_data};
                    end
                end
                ST_PAUSE: begin
                    if (is_err) begin
                        state_nxt = ST_IDLE;
                        skip_nxt  = 3'd0;
                    end else if (skip_cnt == 3'd1) begin
                        act_pause = 1'b1;
                        act_code  = PAUSE_CODE;
                        state_nxt = ST_IDLE;
                        skip_nxt  = 3'd0;
                    end else begin
                        skip_nxt = skip_cnt - 3'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Typematic makes of an already-held key and breaks of an idle key are
    // silent; the Pause event bypasses the bitmap entirely.
    assign key_bit     = key_down[act_code];
    assign make_new    = act_make && !key_bit;
    assign brk_hit     = act_break && key_bit;
    assign parser_push = make_new || brk_hit || act_pause;

    // Held-key bitmap and its incrementally maintained population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down  <= '0;
            keys_held <= 10'd0;
        end else if (act_clear) begin
            key_down  <= '0;
            keys_held <= 10'd0;
        end else if (make_new) begin
            key_down[act_code] <= 1'b1;
            keys_held          <= keys_held + 10'd1;
        end else if (brk_hit) begin
            key_down[act_code] <= 1'b0;
            keys_held          <= keys_held - 10'd1;
        end
    end

    generate
        if (REPEAT_EN) begin : g_rep
            localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int CW = $clog2(RMAX + 1);

            logic          rep_active;
            logic [8:0]    rep_code;
            logic [CW-1:0] rep_cnt;
            logic          retarget;
            logic          cancel;
            logic          rep_held;

            assign retarget    = make_new || act_pause;
            assign cancel      = act_clear || (brk_hit && act_code == rep_code);
            assign rep_held    = rep_active && key_down[rep_code];
            assign rep_req     = rep_held && (rep_cnt == '0);
            assign rep_ev_code = rep_code;

            // Down-counter for the tracked key; sits at zero while a repeat
            // request is waiting behind a parser push.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rep_active <= 1'b0;
                    rep_code   <= 9'd0;
                    rep_cnt    <= '0;
                end else if (retarget) begin
                    rep_active <= 1'b1;
                    rep_code   <= act_code;
                    rep_cnt    <= CW'(REPEAT_DELAY - 1);
                end else if (cancel) begin
                    rep_active <= 1'b0;
                    rep_cnt    <= '0;
                end else if (rep_held) begin
                    if (rep_cnt == '0) begin
                        if (rep_grant) begin
                            rep_cnt <= CW'(REPEAT_RATE - 1);
                        end
                    end else begin
                        rep_cnt <= rep_cnt - CW'(1);
                    end
                end
            end
        end else begin : g_no_rep
            assign rep_req     = 1'b0;
            assign rep_ev_code = 9'd0;
        end
    endgenerate

    // Parser events take the single queue write port ahead of repeats; an
    // AA in the same cycle kills any repeat that was about to fire.
    assign rep_grant = rep_req && !parser_push && !act_clear;
    assign push_req  = parser_push || rep_grant;
    assign push_data = parser_push ? {act_code, act_break, 1'b0}
                                   : {rep_ev_code, 1'b0, 1'b1};

    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop     = (count != '0) && ev_ready;
    assign do_push = push_req && (!full || pop);

    // Queue storage; a full queue that pops can accept a write into the
    // slot being vacated in the same cycle.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && !do_push) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Head fields are forced to zero while empty so stale storage never shows.
    assign head       = mem[rd_ptr];
    assign ev_valid   = (count != '0);
    assign ev_code    = ev_valid ? head[10:2] : 9'd0;
    assign ev_break   = ev_valid ? head[1] : 1'b0;
    assign ev_repeat  = ev_valid ? head[0] : 1'b0;
    assign fifo_count = count;

endmodule
